// File: rtl/moore_pkg.sv
// Shared types and constants for the Moore-detector pattern transmitter.
package moore_pkg;

  localparam int PAT_W = 8;
  localparam int HIT_W = 8;

  typedef logic [3:0] len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_e;

  // A pass length is usable only if it is non-zero and fits in the pattern.
  function automatic logic len_ok(input len_t len, input int max_w);
    return (len != '0) && (int'(len) <= max_w);
  endfunction

endpackage

// File: rtl/moore_pattern_tx_if.sv
// Request/stream/status bundle between a controller and moore_pattern_tx.
interface moore_pattern_tx_if #(
  parameter int W     = moore_pkg::PAT_W,
  parameter int CNT_W = moore_pkg::HIT_W
);

  logic               start;
  logic [W-1:0]       pattern;
  moore_pkg::len_t    len;
  moore_pkg::len_t    reps;
  logic               det_in;
  logic               bit_out;
  logic               bit_valid;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   hit_cnt;

  modport master (
    output start, pattern, len, reps, det_in,
    input  bit_out, bit_valid, busy, done, hit_cnt
  );

  modport slave (
    input  start, pattern, len, reps, det_in,
    output bit_out, bit_valid, busy, done, hit_cnt
  );

endinterface

// File: rtl/moore_pattern_tx_pattern_shift_reg.sv
// Latched pattern plus a wrapping down-counting bit index; bit_o is the bit
// that will be on the wire next cycle, last_o flags the final bit of a pass.
module pattern_shift_reg
  import moore_pkg::*;
#(
  parameter int W = PAT_W
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic         adv_i,
  input  logic [W-1:0] pattern_i,
  input  len_t         len_i,
  output logic         bit_o,
  output logic         last_o
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     pat_q, pat_d;
  len_t             len_q, len_d;
  len_t             idx_q, idx_d;
  logic [IDX_W-1:0] sel;

  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    idx_d = idx_q;
    if (load_i) begin
      pat_d = pattern_i;
      len_d = len_i;
      idx_d = len_i - 4'd1;
    end else if (adv_i) begin
      // Wrapping at the end of a pass reloads the index for the next pass.
      idx_d = (idx_q == '0) ? (len_q - 4'd1) : (idx_q - 4'd1);
    end
  end

  assign sel    = IDX_W'(idx_d);
  assign bit_o  = pat_d[sel];
  assign last_o = (idx_q == '0);

  always_ff @(posedge clk) begin
    pat_q <= pat_d;
    len_q <= len_d;
    idx_q <= idx_d;
  end

endmodule

// File: rtl/moore_pattern_tx.sv
// Serial pattern transmitter feeding a Moore detector, with a saturating hit counter.
// Define MOORE_PATTERN_TX_GAP_EN to insert one idle cycle between passes.
module moore_pattern_tx
  import moore_pkg::*;
#(
  parameter int W     = PAT_W,
  parameter int CNT_W = HIT_W
) (
  input  logic             clk,
  input  logic             rst,
  moore_pattern_tx_if.slave tx
);

  localparam logic [CNT_W-1:0] HIT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == HIT_MAX) ? v : v + 1'b1;
  endfunction

  state_e           state_q, state_d;
  len_t             pass_q, pass_d;
  logic             load, adv, accept;
  logic             sr_bit, sr_last;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] hit_q, hit_d;

  pattern_shift_reg #(.W(W)) u_shift (
    .clk       (clk),
    .load_i    (load),
    .adv_i     (adv),
    .pattern_i (tx.pattern),
    .len_i     (tx.len),
    .bit_o     (sr_bit),
    .last_o    (sr_last)
  );

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    load    = 1'b0;
    adv     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx.start && len_ok(tx.len, W)) begin
          accept  = 1'b1;
          load    = 1'b1;
          pass_d  = tx.reps;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        adv = 1'b1;
        if (sr_last) begin
          if (pass_q != '0) begin
            pass_d = pass_q - 4'd1;
`ifdef MOORE_PATTERN_TX_GAP_EN
            state_d = ST_GAP;
`else
            state_d = ST_SHIFT;
`endif
          end else begin
            state_d = ST_DONE;
          end
        end
      end
`ifdef MOORE_PATTERN_TX_GAP_EN
      ST_GAP:  state_d = ST_SHIFT;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    bit_valid_d = (state_d == ST_SHIFT);
    bit_out_d   = bit_valid_d & sr_bit;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    // Clearing on accept takes priority over a coincident detection.
    hit_d       = accept ? '0 : (tx.det_in ? sat_inc(hit_q) : hit_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= '0;
    end else begin
      state_q     <= state_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
    end
  end

  always_ff @(posedge clk) begin
    pass_q <= pass_d;
  end

  assign tx.bit_out   = bit_out_q;
  assign tx.bit_valid = bit_valid_q;
  assign tx.busy      = busy_q;
  assign tx.done      = done_q;
  assign tx.hit_cnt   = hit_q;

endmodule

// File: tb/tb_moore_pattern_tx.sv
// Directed-vector bench for moore_pattern_tx (default and gap builds).
module tb_moore_pattern_tx;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  moore_pattern_tx_if #(.W(8), .CNT_W(8)) bus ();

  moore_pattern_tx #(.W(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_vec({tag, "/bit_out"},   32'(bus.bit_out),   0);
    check_vec({tag, "/bit_valid"}, 32'(bus.bit_valid), 0);
    check_vec({tag, "/busy"},      32'(bus.busy),      0);
    check_vec({tag, "/done"},      32'(bus.done),      0);
  endtask

  // eb/ev list the expected bit and valid per cycle, first transmitted cycle
  // in bit n-1; det[k] drives det_in during transmit cycle k.
  task automatic send(input string tag, input logic [7:0] pat, input logic [3:0] l,
                      input logic [3:0] r, input int n, input logic [31:0] eb,
                      input logic [31:0] ev, input logic [31:0] det,
                      input bit det0, input bit disturb);
    bus.pattern = pat;
    bus.len     = l;
    bus.reps    = r;
    bus.det_in  = det0;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.det_in  = 1'b0;
    check_vec({tag, "/hit_clr"}, 32'(bus.hit_cnt), 0);
    for (int k = 0; k < n; k++) begin
      check_vec($sformatf("%s/bit%0d", tag, k),  32'(bus.bit_out),   32'(eb[n-1-k]));
      check_vec($sformatf("%s/vld%0d", tag, k),  32'(bus.bit_valid), 32'(ev[n-1-k]));
      check_vec($sformatf("%s/busy%0d", tag, k), 32'(bus.busy),      1);
      check_vec($sformatf("%s/done%0d", tag, k), 32'(bus.done),      0);
      bus.det_in = det[k];
      if (disturb && k == 1) begin
        bus.start   = 1'b1;
        bus.pattern = 8'hFF;
        bus.len     = 4'd8;
        bus.reps    = 4'd3;
      end
      tick();
    end
    bus.start  = 1'b0;
    bus.det_in = 1'b0;
    check_vec({tag, "/done"},      32'(bus.done),      1);
    check_vec({tag, "/done_busy"}, 32'(bus.busy),      1);
    check_vec({tag, "/done_vld"},  32'(bus.bit_valid), 0);
    tick();
    check_vec({tag, "/end_busy"},  32'(bus.busy),      0);
    check_vec({tag, "/end_done"},  32'(bus.done),      0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.reps    = '0;
    bus.det_in  = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    check_vec("reset/hit", 32'(bus.hit_cnt), 0);
    rst = 1'b0;
    tick();

    send("p1011", 8'b0000_1011, 4'd4, 4'd0, 4, 32'b1011, 32'b1111, 0, 1'b0, 1'b0);
    tick();

`ifdef MOORE_PATTERN_TX_GAP_EN
    send("p101x3", 8'b0000_0101, 4'd3, 4'd2, 11, 32'b101_0_101_0_101, 32'b111_0_111_0_111,
         0, 1'b0, 1'b0);
    tick();
    send("len1x3", 8'h01, 4'd1, 4'd2, 5, 32'b10101, 32'b10101, 0, 1'b0, 1'b0);
    tick();
    send("hits", 8'b0000_1011, 4'd4, 4'd1, 9, 32'b1011_0_1011, 32'b1111_0_1111,
         32'b0100_1010, 1'b0, 1'b0);
`else
    send("p101x3", 8'b0000_0101, 4'd3, 4'd2, 9, 32'b101_101_101, 32'b111_111_111,
         0, 1'b0, 1'b0);
    tick();
    send("len1x3", 8'h01, 4'd1, 4'd2, 3, 32'b111, 32'b111, 0, 1'b0, 1'b0);
    tick();
    send("hits", 8'b0000_1011, 4'd4, 4'd1, 8, 32'b1011_1011, 32'b1111_1111,
         32'b0100_1010, 1'b0, 1'b0);
`endif
    // One more detection in the idle cycle right after done.
    bus.det_in = 1'b1;
    tick();
    bus.det_in = 1'b0;
    check_vec("hits/total", 32'(bus.hit_cnt), 4);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_vec("sat/cleared", 32'(bus.hit_cnt), 0);
    bus.det_in = 1'b1;
    repeat (254) tick();
    check_vec("sat/254", 32'(bus.hit_cnt), 254);
    tick();
    check_vec("sat/255", 32'(bus.hit_cnt), 255);
    repeat (45) tick();
    check_vec("sat/hold", 32'(bus.hit_cnt), 255);
    bus.det_in = 1'b0;

    bus.pattern = 8'hFF;
    bus.len     = 4'd0;
    bus.start   = 1'b1;
    tick();
    check_quiet("len0");
    bus.len = 4'd9;
    tick();
    check_quiet("len9");
    bus.start = 1'b0;
    tick();
    check_quiet("illegal_after");
    check_vec("illegal/hit_kept", 32'(bus.hit_cnt), 255);

    send("len8_det", 8'hA5, 4'd8, 4'd0, 8, 32'b1010_0101, 32'hFF, 0, 1'b1, 1'b0);
    tick();

    send("restart", 8'b0011_0010, 4'd6, 4'd0, 6, 32'b110010, 32'b111111, 0, 1'b0, 1'b1);
    tick();
    check_quiet("restart/idle");

    bus.pattern = 8'b0000_1011;
    bus.len     = 4'd4;
    bus.reps    = 4'd0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    check_vec("abort/bit1", 32'(bus.bit_out), 1);
    tick();
    check_vec("abort/bit2", 32'(bus.bit_out), 0);
    check_vec("abort/vld2", 32'(bus.bit_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("abort/rst");
    check_vec("abort/hit", 32'(bus.hit_cnt), 0);
    tick();
    check_quiet("abort/after");
    tick();
    check_quiet("abort/after2");

    send("post_rst", 8'b0000_1011, 4'd4, 4'd0, 4, 32'b1011, 32'b1111, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
